refill_arbiter: RTL and testbench
=================================

Name: refill_arbiter

Overview:
- Shares one memory read-burst port between the icache and dcache line-refill paths.
- Accepts one line-refill request at a time from either cache, using round-robin priority.
- Issues one line-aligned burst address to memory, then steers the 8 returned 64-bit beats back to the granted cache.
- Sits between the cache fill engines and the memory/bus interface.

Parameters:
- ADDR_W, 56, physical address width (44-bit ptag + 6-bit index + 6-bit offset).
- DATA_W, 64, beat width.
- BEATS, 8, beats per line (64-byte line); beat counter width is clog2(BEATS).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  icache refill request.
- ic_req_addr  in  ADDR_W  icache miss address (any offset).
- ic_req_ready  out  1  icache request accepted.
- ic_rsp_valid  out  1  beat valid to icache.
- ic_rsp_data  out  DATA_W  beat data to icache.
- ic_rsp_last  out  1  final beat of line to icache.
- ic_rsp_ready  in  1  icache can take a beat.
- dc_req_valid, dc_req_addr, dc_req_ready, dc_rsp_valid, dc_rsp_data, dc_rsp_last, dc_rsp_ready: same as the ic_ ports, for the dcache.
- mem_ar_valid  out  1  burst address valid.
- mem_ar_addr  out  ADDR_W  line-aligned address, low 6 bits zero.
- mem_ar_ready  in  1  memory accepts address.
- mem_r_valid  in  1  read beat valid.
- mem_r_data  in  DATA_W  read beat.
- mem_r_last  in  1  memory's last-beat flag.
- mem_r_ready  out  1  arbiter accepts beat.
- busy  out  1  a refill is in flight (state != IDLE).
- protocol_err  out  1  sticky: mem_r_last disagreed with the beat count.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, beat_cnt=0, grant_id=0, last_grant=DCACHE (so icache wins the first tie), protocol_err=0.
  - All valid, ready and busy outputs are 0; data outputs are 0.
  - Reset asserted mid-burst abandons the burst immediately: no further rsp_valid, mem_r_ready=0. Memory-side cleanup is the system reset's responsibility.
- States: IDLE, ADDR, DATA (2-bit encoding).
- IDLE:
  - Grant is combinational. Only ic valid -> IC. Only dc valid -> DC. Both valid -> the one not equal to last_grant.
  - req_ready=1 for the granted requester only, in the same cycle.
  - On the handshake: latch {addr[ADDR_W-1:6], 6'b0} and grant_id; set last_grant=grant_id; go to ADDR.
  - Requesters hold valid and addr stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- ADDR:
  - mem_ar_valid=1 with the latched address.
  - On mem_ar_ready -> DATA with beat_cnt=0.
  - The earliest mem_ar_valid is the cycle after the request handshake.
- DATA:
  - Granted rsp_valid = mem_r_valid; granted rsp_data = mem_r_data; mem_r_ready = granted rsp_ready.
  - The non-granted rsp_valid is 0. Both rsp_data buses may carry mem_r_data.
  - A beat transfers when mem_r_valid && mem_r_ready; beat_cnt then increments.
  - rsp_last = (beat_cnt == BEATS-1), derived from the counter, not from mem_r_last.
  - On the transfer with beat_cnt == BEATS-1: go to IDLE, beat_cnt=0. A new request can be granted in that next IDLE cycle.
  - If, on any transfer, mem_r_last != (beat_cnt == BEATS-1): set protocol_err=1 (held until reset). Sequencing continues purely on beat_cnt.
- Back-pressure: combinational passthrough, no buffering. A stalled cache stalls memory.
- Zero-cycle bypass is not allowed: request to first beat is at least 2 cycles.
- Fairness: with both requesters continuously valid, grants alternate IC, DC, IC, DC.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE/ADDR/DATA;
  - requester ids IC=1'b0, DC=1'b1;
  - LINE_OFFSET_W=6.
- One natural sub-module: rr_arbiter2, a 2-requester round-robin grant with a last_grant register and update enable.
- Registers use the team's async-reset flop cells: dff_ar for state/counter/last_grant, dff_aren for the address latch.

Test Plan:
- Single icache request, addr 0x00_1234_5678_9ABC -> mem_ar_addr=0x00_1234_5678_9A80; 8 beats 0..7 delivered to icache; ic_rsp_last on beat 7 only; dc_rsp_valid stays 0; busy drops after the last beat.
- ic and dc both valid from reset -> grant order IC, DC, IC, DC over 4 refills; each line completes before the next mem_ar_valid.
- ic_rsp_ready toggles 1,0,0,1 during DATA with mem_r_valid held 1 -> mem_r_ready mirrors it; 8 beats in order; no beat lost or duplicated.
- Memory asserts mem_r_last on beat 5 -> protocol_err=1 from the next cycle; transfer still completes at beat 7; error persists until reset.
- reset driven low in DATA after beat 3 -> all outputs 0 asynchronously; after release, state IDLE and the icache wins a tie.
- mem_ar_ready held low 10 cycles -> mem_ar_valid and mem_ar_addr stable the whole time; no rsp_valid to either cache.

Source files
------------

// File: rtl/refill_arbiter_pkg.sv
// Shared encodings for the icache/dcache line-refill arbiter.
package refill_arbiter_pkg;

    localparam int LINE_OFFSET_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

endpackage

// File: rtl/refill_arbiter_dff.sv
// Async active-low reset flop cells: plain (dff_ar) and load-enabled (dff_aren).
module dff_ar #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_o <= RST_VAL;
        else        q_o <= d_i;
    end

endmodule

module dff_aren #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    q_o <= RST_VAL;
        else if (en_i) q_o <= d_i;
    end

endmodule

// File: rtl/refill_arbiter_rr.sv
// Two-requester round-robin grant; last_grant advances only when update_i confirms a handshake.
module rr_arbiter2
    import refill_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    req_ic_i,
    input  logic    req_dc_i,
    input  logic    update_i,
    output logic    gnt_valid_o,
    output req_id_e gnt_id_o
);

    logic last_q;
    logic last_d;

    // Reset to DC so the icache wins the first tie.
    dff_ar #(.W(1), .RST_VAL(1'(REQ_DC))) u_last_ff (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (last_d),
        .q_o   (last_q)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_valid_o = req_ic_i | req_dc_i;
        gnt_id_o    = REQ_IC;
        if (req_ic_i && req_dc_i) gnt_id_o = req_id_e'(~last_q);
        else if (req_dc_i)        gnt_id_o = REQ_DC;
        last_d = update_i ? logic'(gnt_id_o) : last_q;
    end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one memory read-burst port between icache and dcache line refills;
// one line in flight at a time, beats steered back to the granted cache.
module refill_arbiter
    import refill_arbiter_pkg::*;
#(
    parameter int ADDR_W = 56,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_rsp_valid,
    output logic [DATA_W-1:0] ic_rsp_data,
    output logic              ic_rsp_last,
    input  logic              ic_rsp_ready,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    output logic              dc_rsp_valid,
    output logic [DATA_W-1:0] dc_rsp_data,
    output logic              dc_rsp_last,
    input  logic              dc_rsp_ready,
    output logic              mem_ar_valid,
    output logic [ADDR_W-1:0] mem_ar_addr,
    input  logic              mem_ar_ready,
    input  logic              mem_r_valid,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_r_last,
    output logic              mem_r_ready,
    output logic              busy,
    output logic              protocol_err
);

    localparam int               CNT_W    = $clog2(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [1:0]        state_raw;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              perr_q, perr_d;
    logic              gid_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              gnt_valid;
    req_id_e           gnt_id;
    logic              req_hs;
    logic              is_last;
    logic              unused_offset;

    assign state_q       = state_e'(state_raw);
    assign unused_offset = ^{ic_req_addr[LINE_OFFSET_W-1:0], dc_req_addr[LINE_OFFSET_W-1:0]};

    rr_arbiter2 u_rr (
        .clk         (clock),
        .rst_n       (reset),
        .req_ic_i    (ic_req_valid),
        .req_dc_i    (dc_req_valid),
        .update_i    (req_hs),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // Gating with reset keeps req_ready low while reset is held even if requests are up.
    assign req_hs       = reset && (state_q == ST_IDLE) && gnt_valid;
    assign ic_req_ready = req_hs && (gnt_id == REQ_IC);
    assign dc_req_ready = req_hs && (gnt_id == REQ_DC);

    assign addr_d = (gnt_id == REQ_DC)
                  ? {dc_req_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}}
                  : {ic_req_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};

    dff_ar  #(.W(2), .RST_VAL(ST_IDLE)) u_state_ff (
        .clk(clock), .rst_n(reset), .d_i(state_d), .q_o(state_raw));
    dff_ar  #(.W(CNT_W))  u_cnt_ff  (.clk(clock), .rst_n(reset), .d_i(cnt_d),  .q_o(cnt_q));
    dff_ar  #(.W(1))      u_perr_ff (.clk(clock), .rst_n(reset), .d_i(perr_d), .q_o(perr_q));
    dff_aren #(.W(1))     u_gid_ff  (.clk(clock), .rst_n(reset), .en_i(req_hs),
                                     .d_i(gnt_id), .q_o(gid_q));
    dff_aren #(.W(ADDR_W)) u_addr_ff (.clk(clock), .rst_n(reset), .en_i(req_hs),
                                      .d_i(addr_d), .q_o(addr_q));

    assign is_last      = (cnt_q == CNT_LAST);
    assign busy         = (state_q != ST_IDLE);
    assign mem_ar_addr  = addr_q;
    assign protocol_err = perr_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        perr_d       = perr_q;
        mem_ar_valid = 1'b0;
        mem_r_ready  = 1'b0;
        ic_rsp_valid = 1'b0;
        ic_rsp_last  = 1'b0;
        ic_rsp_data  = '0;
        dc_rsp_valid = 1'b0;
        dc_rsp_last  = 1'b0;
        dc_rsp_data  = '0;
        unique case (state_q)
            ST_IDLE: if (req_hs) state_d = ST_ADDR;
            ST_ADDR: begin
                mem_ar_valid = 1'b1;
                if (mem_ar_ready) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                ic_rsp_data = mem_r_data;
                dc_rsp_data = mem_r_data;
                if (gid_q == REQ_IC) begin
                    ic_rsp_valid = mem_r_valid;
                    ic_rsp_last  = is_last;
                    mem_r_ready  = ic_rsp_ready;
                end else begin
                    dc_rsp_valid = mem_r_valid;
                    dc_rsp_last  = is_last;
                    mem_r_ready  = dc_rsp_ready;
                end
                // Sequencing follows the beat counter; mem_r_last is only cross-checked.
                if (mem_r_valid && mem_r_ready) begin
                    if (mem_r_last != is_last) perr_d = 1'b1;
                    if (is_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Randomised bench for refill_arbiter against a transaction-level reference model.
module tb_refill_arbiter;

    localparam int ADDR_W = 56;
    localparam int DATA_W = 64;
    localparam int BEATS  = 8;

    logic              clock;
    logic              reset;
    logic              ic_req_valid, ic_req_ready, ic_rsp_valid, ic_rsp_last, ic_rsp_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic [DATA_W-1:0] ic_rsp_data;
    logic              dc_req_valid, dc_req_ready, dc_rsp_valid, dc_rsp_last, dc_rsp_ready;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_rsp_data;
    logic              mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_last, mem_r_ready;
    logic [ADDR_W-1:0] mem_ar_addr;
    logic [DATA_W-1:0] mem_r_data;
    logic              busy, protocol_err;

    refill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clock        (clock),
        .reset        (reset),
        .ic_req_valid (ic_req_valid),
        .ic_req_addr  (ic_req_addr),
        .ic_req_ready (ic_req_ready),
        .ic_rsp_valid (ic_rsp_valid),
        .ic_rsp_data  (ic_rsp_data),
        .ic_rsp_last  (ic_rsp_last),
        .ic_rsp_ready (ic_rsp_ready),
        .dc_req_valid (dc_req_valid),
        .dc_req_addr  (dc_req_addr),
        .dc_req_ready (dc_req_ready),
        .dc_rsp_valid (dc_rsp_valid),
        .dc_rsp_data  (dc_rsp_data),
        .dc_rsp_last  (dc_rsp_last),
        .dc_rsp_ready (dc_rsp_ready),
        .mem_ar_valid (mem_ar_valid),
        .mem_ar_addr  (mem_ar_addr),
        .mem_ar_ready (mem_ar_ready),
        .mem_r_valid  (mem_r_valid),
        .mem_r_data   (mem_r_data),
        .mem_r_last   (mem_r_last),
        .mem_r_ready  (mem_r_ready),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one refill in flight, phase 0 idle / 1 address / 2 beats.
    int                m_phase;
    bit                m_owner;
    bit                m_last_owner;
    logic [ADDR_W-1:0] m_line;
    int                m_beats;
    bit                m_err;
    bit                hs_ic, hs_dc;
    bit                grant_log[$];
    int                ic_beats_seen;

    int p_ic_req, p_dc_req, p_drop, p_ar, p_rv, p_rdy;
    int inject_at = -1;
    bit rdy_pat[$];

    function automatic bit coin(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[ADDR_W-1:0];
    endfunction

    task automatic set_pol(input int ic, input int dc, input int drop,
                           input int ar, input int rv, input int rdy);
        p_ic_req = ic; p_dc_req = dc; p_drop = drop; p_ar = ar; p_rv = rv; p_rdy = rdy;
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last_owner = 1; m_line = '0; m_beats = 0;
        m_err = 0; hs_ic = 0; hs_dc = 0; inject_at = -1;
        rdy_pat.delete();
    endtask

    task automatic check_and_update();
        bit g_valid, g_id, own_rdy, exp_ic_v, exp_dc_v;
        g_valid = ic_req_valid | dc_req_valid;
        g_id    = (ic_req_valid && dc_req_valid) ? !m_last_owner : !ic_req_valid;
        own_rdy = m_owner ? dc_rsp_ready : ic_rsp_ready;
        exp_ic_v = (m_phase == 2) && !m_owner && mem_r_valid;
        exp_dc_v = (m_phase == 2) &&  m_owner && mem_r_valid;

        check("busy", busy, m_phase != 0);
        check("ic_req_ready", ic_req_ready, m_phase == 0 && g_valid && !g_id);
        check("dc_req_ready", dc_req_ready, m_phase == 0 && g_valid &&  g_id);
        check("mem_ar_valid", mem_ar_valid, m_phase == 1);
        if (m_phase == 1) check("mem_ar_addr", mem_ar_addr, m_line);
        check("ic_rsp_valid", ic_rsp_valid, exp_ic_v);
        check("dc_rsp_valid", dc_rsp_valid, exp_dc_v);
        check("mem_r_ready", mem_r_ready, m_phase == 2 && own_rdy);
        if (exp_ic_v) begin
            check("ic_rsp_data", ic_rsp_data, mem_r_data);
            check("ic_rsp_last", ic_rsp_last, m_beats == BEATS - 1);
        end
        if (exp_dc_v) begin
            check("dc_rsp_data", dc_rsp_data, mem_r_data);
            check("dc_rsp_last", dc_rsp_last, m_beats == BEATS - 1);
        end
        check("protocol_err", protocol_err, m_err);
        if (ic_rsp_valid && ic_rsp_ready) ic_beats_seen++;

        hs_ic = 0; hs_dc = 0;
        case (m_phase)
            0: if (g_valid) begin
                m_owner      = g_id;
                m_last_owner = g_id;
                m_line       = g_id ? dc_req_addr : ic_req_addr;
                m_line[5:0]  = '0;
                grant_log.push_back(g_id);
                if (g_id) hs_dc = 1; else hs_ic = 1;
                m_phase = 1;
            end
            1: if (mem_ar_ready) begin
                m_phase = 2;
                m_beats = 0;
            end
            default: if (mem_r_valid && own_rdy) begin
                if (mem_r_last !== (m_beats == BEATS - 1)) m_err = 1;
                if (m_beats == BEATS - 1) m_phase = 0;
                else m_beats++;
            end
        endcase
    endtask

    task automatic drive();
        bit dropped;
        dropped = 0;
        if (hs_ic) ic_req_valid = 0;
        else if (ic_req_valid && coin(p_drop)) begin ic_req_valid = 0; dropped = 1; end
        if (!ic_req_valid && !dropped && coin(p_ic_req)) begin
            ic_req_valid = 1; ic_req_addr = rand_addr();
        end
        dropped = 0;
        if (hs_dc) dc_req_valid = 0;
        else if (dc_req_valid && coin(p_drop)) begin dc_req_valid = 0; dropped = 1; end
        if (!dc_req_valid && !dropped && coin(p_dc_req)) begin
            dc_req_valid = 1; dc_req_addr = rand_addr();
        end
        mem_ar_ready = coin(p_ar);
        mem_r_valid  = coin(p_rv);
        mem_r_data   = {$urandom(), $urandom()};
        mem_r_last   = (m_phase == 2) &&
                       (inject_at >= 0 ? m_beats == inject_at : m_beats == BEATS - 1);
        if (rdy_pat.size() > 0 && m_phase == 2) ic_rsp_ready = rdy_pat.pop_front();
        else ic_rsp_ready = coin(p_rdy);
        dc_rsp_ready = coin(p_rdy);
    endtask

    task automatic step();
        @(negedge clock);
        check_and_update();
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (m_phase != 0 && n < budget);
        if (m_phase != 0) check(tag, m_phase, 0);
    endtask

    task automatic clear_inputs();
        ic_req_valid = 0; ic_req_addr = '0; ic_rsp_ready = 0;
        dc_req_valid = 0; dc_req_addr = '0; dc_rsp_ready = 0;
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = '0; mem_r_last = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        clear_inputs();
        set_pol(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 0;
        clear_inputs();
        model_reset();
        set_pol(100, 100, 0, 100, 100, 100);
        ic_req_valid = 1; ic_req_addr = rand_addr();
        dc_req_valid = 1; dc_req_addr = rand_addr();
        mem_r_valid  = 1; ic_rsp_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ic_req_ready", ic_req_ready, 0);
        check("rst_dc_req_ready", dc_req_ready, 0);
        check("rst_ar_valid", mem_ar_valid, 0);
        check("rst_ar_addr", mem_ar_addr, 0);
        check("rst_r_ready", mem_r_ready, 0);
        check("rst_ic_rsp_valid", ic_rsp_valid, 0);
        check("rst_ic_rsp_data", ic_rsp_data, 0);
        check("rst_perr", protocol_err, 0);
        reset = 1;

        // Both requesters valid from reset: grants must alternate starting with icache.
        grant_log.delete();
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin step(); n++; end
        check("rr_grant_count", grant_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
        set_pol(0, 0, 100, 100, 100, 100);
        repeat (2) step();
        wait_idle("rr_drain", 200);

        // Single icache line refill at a non-aligned address.
        do_reset();
        set_pol(0, 0, 0, 100, 100, 100);
        ic_req_valid = 1; ic_req_addr = 56'h00_1234_5678_9ABC;
        ic_beats_seen = 0;
        step();
        #1;
        check("t1_ar_addr", mem_ar_addr, 56'h00_1234_5678_9A80);
        wait_idle("t1_timeout", 50);
        check("t1_ic_beats", ic_beats_seen, BEATS);

        // Icache back-pressure pattern with memory always presenting a beat.
        do_reset();
        set_pol(0, 0, 0, 100, 100, 0);
        repeat (6) begin rdy_pat.push_back(1); rdy_pat.push_back(0);
                         rdy_pat.push_back(0); rdy_pat.push_back(1); end
        ic_req_valid = 1; ic_req_addr = rand_addr();
        ic_beats_seen = 0;
        step();
        wait_idle("t3_timeout", 80);
        check("t3_ic_beats", ic_beats_seen, BEATS);
        rdy_pat.delete();

        // Early mem_r_last on beat 5: sticky error, line still runs to beat 7.
        do_reset();
        set_pol(0, 0, 0, 100, 100, 100);
        inject_at = 5;
        ic_req_valid = 1; ic_req_addr = rand_addr();
        ic_beats_seen = 0;
        step();
        wait_idle("t4_timeout", 50);
        check("t4_ic_beats", ic_beats_seen, BEATS);
        check("t4_perr", protocol_err, 1);
        inject_at = -1;
        set_pol(30, 30, 5, 50, 60, 60);
        repeat (40) step();
        check("t4_perr_sticky", protocol_err, 1);
        set_pol(0, 0, 100, 100, 100, 100);
        repeat (2) step();
        wait_idle("t4_drain", 100);
        do_reset();
        #1;
        check("t4_perr_cleared", protocol_err, 0);

        // Reset asserted mid-burst after beat 3.
        set_pol(0, 0, 0, 100, 100, 100);
        ic_req_valid = 1; ic_req_addr = rand_addr();
        n = 0;
        do begin step(); n++; end while (!(m_phase == 2 && m_beats == 4) && n < 50);
        check("t5_reached_beat4", m_beats, 4);
        #1;
        reset = 0;
        ic_req_valid = 1; dc_req_valid = 1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_r_ready", mem_r_ready, 0);
        check("t5_ic_rsp_valid", ic_rsp_valid, 0);
        check("t5_ic_rsp_data", ic_rsp_data, 0);
        check("t5_ic_rsp_last", ic_rsp_last, 0);
        check("t5_ar_valid", mem_ar_valid, 0);
        check("t5_ic_req_ready", ic_req_ready, 0);
        check("t5_dc_req_ready", dc_req_ready, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
        model_reset();
        #1;
        check("t5_tie_ic_ready", ic_req_ready, 1);
        check("t5_tie_dc_ready", dc_req_ready, 0);
        step();
        dc_req_valid = 0;
        wait_idle("t5_timeout", 50);

        // Memory withholds mem_ar_ready for 10 cycles.
        do_reset();
        set_pol(0, 0, 0, 0, 100, 100);
        ic_req_valid = 1; ic_req_addr = rand_addr();
        step();
        repeat (10) step();
        #1;
        check("t6_ar_held", mem_ar_valid, 1);
        check("t6_ar_addr", mem_ar_addr, m_line);
        set_pol(0, 0, 0, 100, 100, 100);
        wait_idle("t6_timeout", 50);

        // Randomised traffic on both requesters and the memory side.
        do_reset();
        set_pol(40, 40, 5, 50, 70, 70);
        repeat (3000) step();
        set_pol(0, 0, 100, 100, 100, 100);
        repeat (2) step();
        wait_idle("rand_drain", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
